mem_port_arbiter: RTL and testbench

- Shares one single-port, fixed-latency unified memory between instruction fetch (IF, read-only) and the data-memory stage (MEM, read/write) of the pipelined core.
- Grants one access at a time, sequences the issue/wait phases, returns read data to the owner and drives stall outputs to the PC / IF_ID register and to the whole pipeline.
- Priority: MEM over IF (older instruction first).

---
 rtl/mem_port_arbiter_if.sv | 39 +++
 rtl/mem_port_arbiter.sv | 154 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of fetch, data-stage and memory-side signals for the unified memory port arbiter.
// slave = arbiter view; master = core/memory environment view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_valid;

    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_valid;

    logic              stall_if;
    logic              stall_mem;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        output if_rdata, if_valid, dm_rdata, dm_valid, stall_if, stall_mem,
               mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
        input  if_rdata, if_valid, dm_rdata, dm_valid, stall_if, stall_mem,
               mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates one fixed-latency single-port memory between instruction fetch and the data stage.
// Optional macro ARB_FAIR_EN bounds consecutive data grants while fetch is waiting.
module mem_port_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int LATENCY        = 2,
    parameter int MAX_DATA_BURST = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);

    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
        $error("mem_port_arbiter: LATENCY must be within 1..15");
    end
    if (MAX_DATA_BURST < 1) begin : g_bad_burst
        $error("mem_port_arbiter: MAX_DATA_BURST must be at least 1");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
    typedef enum logic {OWN_IF, OWN_DM} owner_e;

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    state_e            state_q,     state_d;
    owner_e            owner_q,     owner_d;
    logic              acc_we_q,    acc_we_d;
    logic [3:0]        cnt_q,       cnt_d;
    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic if_starved;
    logic grant_dm;
    logic grant_if;
    logic done;

`ifdef ARB_FAIR_EN
    localparam int BW = $clog2(MAX_DATA_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_DATA_BURST);

    logic [BW-1:0] burst_q, burst_d;

    assign if_starved = bus.if_req && (burst_q >= BURST_MAX);

    // Counts data grants made while fetch waits; any fetch grant or idle cycle
    // without a fetch request restarts the window.
    always_comb begin
        burst_d = burst_q;
        if (state_q == IDLE) begin
            if (!bus.if_req || grant_if) begin
                burst_d = '0;
            end else if (grant_dm && burst_q != BURST_MAX) begin
                burst_d = burst_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end
`else
    assign if_starved = 1'b0;
`endif

    assign grant_dm = (state_q == IDLE) && bus.dm_req && !if_starved;
    assign grant_if = (state_q == IDLE) && bus.if_req && !grant_dm;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        acc_we_d    = acc_we_q;
        cnt_d       = cnt_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        case (state_q)
            IDLE: begin
                if (grant_dm) begin
                    owner_d     = OWN_DM;
                    acc_we_d    = bus.dm_we;
                    mem_en_d    = 1'b1;
                    mem_we_d    = bus.dm_we;
                    mem_addr_d  = bus.dm_addr;
                    mem_wdata_d = bus.dm_wdata;
                    state_d     = ISSUE;
                end else if (grant_if) begin
                    owner_d    = OWN_IF;
                    acc_we_d   = 1'b0;
                    mem_en_d   = 1'b1;
                    mem_addr_d = bus.if_addr;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = CNT_LOAD;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset also drops any in-flight access: the late response lands in IDLE and is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= OWN_IF;
            acc_we_q    <= 1'b0;
            cnt_q       <= 4'd0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            acc_we_q    <= acc_we_d;
            cnt_q       <= cnt_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign done = (state_q == WAIT) && (cnt_q == 4'd0);

    assign bus.if_valid  = done && (owner_q == OWN_IF);
    assign bus.dm_valid  = done && (owner_q == OWN_DM);
    assign bus.if_rdata  = bus.if_valid ? bus.mem_rdata : '0;
    assign bus.dm_rdata  = (bus.dm_valid && !acc_we_q) ? bus.mem_rdata : '0;
    assign bus.stall_if  = bus.if_req && !bus.if_valid;
    assign bus.stall_mem = bus.dm_req && !bus.dm_valid;

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: cycle-scheduled transaction model plus directed pins.
// A second LATENCY=1 instance runs under a continuous fetch stream.
module tb_mem_port_arbiter;
    localparam int LAT  = 2;
    localparam int MAXB = 4;
`ifdef ARB_FAIR_EN
    localparam bit FAIR = 1'b1;
`else
    localparam bit FAIR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus  ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(LAT), .MAX_DATA_BURST(MAXB)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave));
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .LATENCY(1), .MAX_DATA_BURST(MAXB)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Transaction model: a grant in idle cycle t issues at t+1 and completes at t+1+LAT.
    bit          chk_on = 1'b0;
    int          cyc = 0;
    bit          m_busy = 1'b0;
    bit          m_dm, m_we;
    int          m_issue, m_done;
    int          m_burst = 0;
    logic [31:0] m_addr = 32'h0;
    logic [31:0] m_wdata = 32'h0;
    bit          last_ifv = 1'b0, last_dmv = 1'b0;
    bit          e_en, e_ifv, e_dmv, starve;

    always @(negedge clk) if (chk_on) begin
        e_en  = m_busy && (cyc == m_issue);
        e_ifv = m_busy && (cyc == m_done) && !m_dm;
        e_dmv = m_busy && (cyc == m_done) && m_dm;
        chk("mem_en",    bus.mem_en,    e_en);
        chk("mem_we",    bus.mem_we,    e_en && m_we);
        chk("mem_addr",  bus.mem_addr,  m_addr);
        if (e_en && m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
        chk("if_valid",  bus.if_valid,  e_ifv);
        chk("dm_valid",  bus.dm_valid,  e_dmv);
        chk("if_rdata",  bus.if_rdata,  e_ifv ? bus.mem_rdata : 32'h0);
        chk("dm_rdata",  bus.dm_rdata,  (e_dmv && !m_we) ? bus.mem_rdata : 32'h0);
        chk("stall_if",  bus.stall_if,  bus.if_req && !e_ifv);
        chk("stall_mem", bus.stall_mem, bus.dm_req && !e_dmv);
        last_ifv = e_ifv;
        last_dmv = e_dmv;
        if (rst) begin
            m_busy = 1'b0; m_addr = 32'h0; m_wdata = 32'h0; m_burst = 0;
        end else if (m_busy) begin
            if (cyc == m_done) m_busy = 1'b0;
        end else begin
            starve = FAIR && bus.if_req && (m_burst >= MAXB);
            if (bus.dm_req && !starve) begin
                m_busy = 1'b1; m_dm = 1'b1; m_we = bus.dm_we;
                m_addr = bus.dm_addr; m_wdata = bus.dm_wdata;
                m_burst = bus.if_req ? ((m_burst < MAXB) ? m_burst + 1 : MAXB) : 0;
            end else if (bus.if_req) begin
                m_busy = 1'b1; m_dm = 1'b0; m_we = 1'b0;
                m_addr = bus.if_addr;
                m_burst = 0;
            end else begin
                m_burst = 0;
            end
            m_issue = cyc + 1;
            m_done  = cyc + 1 + LAT;
        end
        cyc++;
    end

    // LATENCY=1 instance with if_req always high: idle, issue, valid repeating.
    int p1 = 0;
    always @(negedge clk) if (chk_on) begin
        chk("l1_mem_en",   bus1.mem_en,   p1 == 1);
        chk("l1_if_valid", bus1.if_valid, p1 == 2);
        chk("l1_if_rdata", bus1.if_rdata, (p1 == 2) ? bus1.mem_rdata : 32'h0);
        chk("l1_stall_if", bus1.stall_if, p1 != 2);
        p1 = rst ? 0 : (p1 + 1) % 3;
    end

    task automatic nxt();
        @(posedge clk);
        #1;
        bus1.mem_rdata = $urandom;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    bit glog [10];
    int gn;

    initial begin
        bus.if_req = 0; bus.if_addr = 0; bus.dm_req = 0; bus.dm_we = 0;
        bus.dm_addr = 0; bus.dm_wdata = 0; bus.mem_rdata = 0;
        bus1.if_req = 1; bus1.if_addr = 32'h40; bus1.dm_req = 0; bus1.dm_we = 0;
        bus1.dm_addr = 0; bus1.dm_wdata = 0; bus1.mem_rdata = 0;

        nxt(); chk_on = 1'b1;
        smp();
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_if_valid", bus.if_valid, 0);
        chk("rst_dm_rdata", bus.dm_rdata, 0);
        nxt(); rst = 0;

        // Fetch read, LATENCY=2
        bus.if_req = 1; bus.if_addr = 32'h100;
        smp(); chk("d1_stall_c0", bus.stall_if, 1);
        nxt(); smp();
        chk("d1_mem_en_c1", bus.mem_en, 1); chk("d1_mem_we_c1", bus.mem_we, 0);
        chk("d1_addr_c1", bus.mem_addr, 32'h100);
        nxt(); smp(); chk("d1_stall_c2", bus.stall_if, 1);
        nxt(); bus.mem_rdata = 32'hDEADBEEF; smp();
        chk("d1_valid_c3", bus.if_valid, 1); chk("d1_rdata_c3", bus.if_rdata, 32'hDEADBEEF);
        chk("d1_stall_c3", bus.stall_if, 0);

        // Data write
        nxt(); bus.if_req = 0; bus.mem_rdata = 32'hFFFFFFFF;
        bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h2004; bus.dm_wdata = 32'h12345678;
        smp(); chk("d2_stall_c0", bus.stall_mem, 1);
        nxt(); smp();
        chk("d2_mem_en_c1", bus.mem_en, 1); chk("d2_mem_we_c1", bus.mem_we, 1);
        chk("d2_addr_c1", bus.mem_addr, 32'h2004); chk("d2_wdata_c1", bus.mem_wdata, 32'h12345678);
        nxt(); smp(); chk("d2_stall_c2", bus.stall_mem, 1); chk("d2_we_c2", bus.mem_we, 0);
        nxt(); smp();
        chk("d2_valid_c3", bus.dm_valid, 1); chk("d2_rdata_c3", bus.dm_rdata, 0);
        chk("d2_stall_c3", bus.stall_mem, 0);

        // Simultaneous requests: data first, fetch after
        nxt(); bus.dm_we = 0; bus.dm_addr = 32'h400; bus.mem_rdata = 32'h0BADF00D;
        bus.if_req = 1; bus.if_addr = 32'h300;
        smp(); nxt(); smp();
        chk("d3_mem_en_c1", bus.mem_en, 1); chk("d3_addr_c1", bus.mem_addr, 32'h400);
        nxt(); nxt(); smp();
        chk("d3_dm_valid_c3", bus.dm_valid, 1); chk("d3_dm_rdata_c3", bus.dm_rdata, 32'h0BADF00D);
        chk("d3_stall_if_c3", bus.stall_if, 1);
        nxt(); bus.dm_req = 0;
        nxt(); smp();
        chk("d3_mem_en_c5", bus.mem_en, 1); chk("d3_addr_c5", bus.mem_addr, 32'h300);
        nxt(); smp(); chk("d3_stall_if_c6", bus.stall_if, 1);
        nxt(); smp();
        chk("d3_if_valid_c7", bus.if_valid, 1); chk("d3_if_rdata_c7", bus.if_rdata, 32'h0BADF00D);

        // Reset during the wait phase of a fetch
        nxt(); bus.if_addr = 32'h700;
        nxt(); smp(); chk("d4_mem_en_c1", bus.mem_en, 1);
        nxt(); rst = 1; bus.if_req = 0;
        nxt(); rst = 0; bus.mem_rdata = 32'h5555AAAA; smp();
        chk("d4_if_valid_c3", bus.if_valid, 0); chk("d4_if_rdata_c3", bus.if_rdata, 0);
        chk("d4_mem_addr_c3", bus.mem_addr, 0); chk("d4_mem_en_c3", bus.mem_en, 0);
        nxt(); smp(); chk("d4_if_valid_c4", bus.if_valid, 0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            nxt();
            bus.mem_rdata = $urandom;
            rst = ($urandom_range(0, 199) == 0);
            if (bus.if_req && last_ifv) bus.if_req = 0;
            if (bus.dm_req && last_dmv) bus.dm_req = 0;
            if (bus.dm_req && $urandom_range(0, 99) == 0) bus.dm_req = 0;
            if (!bus.if_req && $urandom_range(0, 2) == 0) begin
                bus.if_req = 1; bus.if_addr = $urandom;
            end
            if (!bus.dm_req && $urandom_range(0, 3) == 0) begin
                bus.dm_req = 1; bus.dm_we = $urandom; bus.dm_addr = $urandom; bus.dm_wdata = $urandom;
            end
        end
        nxt(); rst = 0; bus.if_req = 0; bus.dm_req = 0;
        repeat (20) nxt();

        // Both requesters held: grant order reveals the fairness window
        bus.if_req = 1; bus.if_addr = 32'h500;
        bus.dm_req = 1; bus.dm_we = 0; bus.dm_addr = 32'h600;
        gn = 0;
        for (int c = 0; c < 60; c++) begin
            smp();
            if (bus.mem_en === 1'b1 && gn < 10) begin
                glog[gn] = (bus.mem_addr == 32'h500);
                gn++;
            end
            nxt();
        end
        chk("grant_count", gn, 10);
        for (int k = 0; k < 10; k++)
            if (k < gn) chk($sformatf("grant_is_if_%0d", k), glog[k], FAIR && (k == 4 || k == 9));
        bus.if_req = 0; bus.dm_req = 0;
        repeat (8) nxt();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
